// File: rtl/video_timing_streamer.sv
// video_timing_streamer: programmable raster timing generator driving RGB/sync pins from a valid/ready pixel stream.
// Optional macro VTS_TEST_PATTERN_EN adds iPatternSel and an internal 8-bar colour pattern.
module video_timing_streamer #(
   parameter int   pHdisplayWidth = 11,
   parameter int   pVdisplayWidth = 11,
   parameter int   pChBits        = 4,
   parameter logic pHSyncPol      = 1'b0,
   parameter logic pVSyncPol      = 1'b0
) (
   input  logic                     iClk,
   input  logic                     iRst,
   input  logic                     iEn,
   input  logic [pHdisplayWidth:0]  iHdisplay,
   input  logic [pHdisplayWidth:0]  iHSyncStart,
   input  logic [pHdisplayWidth:0]  iHSyncEnd,
   input  logic [pHdisplayWidth:0]  iHSyncMax,
   input  logic [pVdisplayWidth:0]  iVdisplay,
   input  logic [pVdisplayWidth:0]  iVSyncStart,
   input  logic [pVdisplayWidth:0]  iVSyncEnd,
   input  logic [pVdisplayWidth:0]  iVSyncMax,
   input  logic [3*pChBits-1:0]     iPixel,
   input  logic                     iPixelVd,
`ifdef VTS_TEST_PATTERN_EN
   input  logic                     iPatternSel,
`endif
   output logic                     oPixelRdy,
   output logic [pChBits-1:0]       oColorR,
   output logic [pChBits-1:0]       oColorG,
   output logic [pChBits-1:0]       oColorB,
   output logic                     oHSync,
   output logic                     oVSync,
   output logic                     oDe,
   output logic                     oFe,
   output logic                     oLe,
   output logic                     oUnderflow,
   input  logic                     iUnderflowClr,
   output logic [pHdisplayWidth:0]  oHCnt,
   output logic [pVdisplayWidth:0]  oVCnt
);
   localparam logic [pHdisplayWidth:0] H_ONE = 1;
   localparam logic [pVdisplayWidth:0] V_ONE = 1;
   typedef enum logic [1:0] {IDLE, LOAD, RUN} state_t;
   state_t                    state_q;
   logic [pHdisplayWidth:0]   hcnt_q, hdisp_q, hs_start_q, hs_end_q, hmax_q;
   logic [pVdisplayWidth:0]   vcnt_q, vdisp_q, vs_start_q, vs_end_q, vmax_q;
   logic [3*pChBits-1:0]      rgb_q, rgb_d, pat_rgb;
   logic                      de_q, hs_q, vs_q, le_q, fe_q, uf_q, uf_d;
   logic                      run, h_wrap, v_wrap, frame_end, load, active, hs_act, vs_act, pat, xfer, starve;

   assign run       = state_q == RUN;
   assign h_wrap    = run && hcnt_q == hmax_q;
   assign v_wrap    = vcnt_q == vmax_q;
   assign frame_end = h_wrap && v_wrap;
   // The restart load rides on the frame-end edge so the next frame begins without a dead cycle.
   assign load      = state_q == LOAD || (frame_end && iEn);
   assign active    = run && hcnt_q < hdisp_q && vcnt_q < vdisp_q;
   assign hs_act    = run && hcnt_q >= hs_start_q && hcnt_q <= hs_end_q;
   assign vs_act    = run && vcnt_q >= vs_start_q && vcnt_q <= vs_end_q;
   assign oPixelRdy = active && !pat;
   assign xfer      = oPixelRdy && iPixelVd;
   assign starve    = oPixelRdy && !iPixelVd;
   assign rgb_d     = !active ? '0 : pat ? pat_rgb : xfer ? iPixel : '0;
   assign uf_d      = starve || (uf_q && !iUnderflowClr);

`ifdef VTS_TEST_PATTERN_EN
   logic [pHdisplayWidth:0] bar_cnt_q, bar_w;
   logic [2:0]              bar_q;
   assign pat     = iPatternSel;
   assign bar_w   = hdisp_q >> 3;
   assign pat_rgb = {{pChBits{bar_q[2]}}, {pChBits{bar_q[1]}}, {pChBits{bar_q[0]}}};
   // Bar index steps every Hdisplay/8 active pixels and restarts on each line.
   always_ff @(posedge iClk or negedge iRst) begin
      if (!iRst) begin
         bar_cnt_q <= '0;
         bar_q     <= '0;
      end else if (!active || h_wrap) begin
         bar_cnt_q <= '0;
         bar_q     <= '0;
      end else if (bar_cnt_q + H_ONE >= bar_w) begin
         bar_cnt_q <= '0;
         bar_q     <= bar_q == 3'd7 ? bar_q : bar_q + 3'd1;
      end else begin
         bar_cnt_q <= bar_cnt_q + H_ONE;
      end
   end
`else
   assign pat     = 1'b0;
   assign pat_rgb = '0;
`endif

   // Frame FSM and raster counters; counters sit at 0 whenever not running.
   always_ff @(posedge iClk or negedge iRst) begin
      if (!iRst) begin
         state_q <= IDLE;
         hcnt_q  <= '0;
         vcnt_q  <= '0;
      end else begin
         case (state_q)
            IDLE: state_q <= iEn ? LOAD : IDLE;
            LOAD: state_q <= RUN;
            RUN: begin
               hcnt_q <= h_wrap ? '0 : hcnt_q + H_ONE;
               if (h_wrap) vcnt_q <= v_wrap ? '0 : vcnt_q + V_ONE;
               if (frame_end && !iEn) state_q <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   // Shadow timing set; inputs are only sampled when a frame is about to start.
   always_ff @(posedge iClk or negedge iRst) begin
      if (!iRst) begin
         {hdisp_q, hs_start_q, hs_end_q, hmax_q} <= '0;
         {vdisp_q, vs_start_q, vs_end_q, vmax_q} <= '0;
      end else if (load) begin
         {hdisp_q, hs_start_q, hs_end_q, hmax_q} <= {iHdisplay, iHSyncStart, iHSyncEnd, iHSyncMax};
         {vdisp_q, vs_start_q, vs_end_q, vmax_q} <= {iVdisplay, iVSyncStart, iVSyncEnd, iVSyncMax};
      end
   end

   // Pin registers: one cycle behind the raster state, all aligned.
   always_ff @(posedge iClk or negedge iRst) begin
      if (!iRst) begin
         rgb_q <= '0;
         de_q  <= 1'b0;
         hs_q  <= ~pHSyncPol;
         vs_q  <= ~pVSyncPol;
         le_q  <= 1'b0;
         fe_q  <= 1'b0;
         uf_q  <= 1'b0;
      end else begin
         rgb_q <= rgb_d;
         de_q  <= active;
         hs_q  <= hs_act ? pHSyncPol : ~pHSyncPol;
         vs_q  <= vs_act ? pVSyncPol : ~pVSyncPol;
         le_q  <= h_wrap;
         fe_q  <= frame_end;
         uf_q  <= uf_d;
      end
   end

   assign {oColorR, oColorG, oColorB} = rgb_q;
   assign oDe        = de_q;
   assign oHSync     = hs_q;
   assign oVSync     = vs_q;
   assign oLe        = le_q;
   assign oFe        = fe_q;
   assign oUnderflow = uf_q;
   assign oHCnt      = hcnt_q;
   assign oVCnt      = vcnt_q;
endmodule
